// File: rtl/e203_exu_dsp_wbck_pkg.sv
// Shared widths and the buffered entry layout for the DSP writeback buffer.
// Widths mirror E203_XLEN / E203_RFIDX_WIDTH from e203_defines.v.
package e203_exu_dsp_wbck_pkg;

    localparam int E203_XLEN        = 32;
    localparam int E203_RFIDX_WIDTH = 5;
    localparam int DSP_WBCK_DW      = E203_XLEN + E203_RFIDX_WIDTH + 2;

    typedef struct packed {
        logic                        ov;
        logic                        err;
        logic [E203_RFIDX_WIDTH-1:0] rdidx;
        logic [E203_XLEN-1:0]        wdat;
    } dsp_wbck_ent_t;

endpackage

// File: rtl/e203_exu_dsp_wbck_buf.sv
// Two-entry FIFO with 1-bit wrapping pointers and a registered occupancy count.
// Storage is not reset; only the count and pointers are.
module e203_exu_dsp_wbck_buf #(
    parameter int DP = 2,
    parameter int DW = 39
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [DW-1:0] i_wdat,
    output logic [DW-1:0] o_rdat,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [0:DP-1];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else if (i_flush) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // A flushed push must not land, but the slot is free anyway so no guard needed beyond i_push.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdat;
    end

    assign o_rdat  = r_mem[r_rptr];
    assign o_full  = r_cnt[1];
    assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/e203_exu_dsp_wbck.sv
// DSP writeback result buffer: decouples the shift/ALU stage from the writeback
// arbiter with a 2-deep FIFO and keeps the sticky saturation (OV) flag.
module e203_exu_dsp_wbck
    import e203_exu_dsp_wbck_pkg::*;
#(
    parameter int DP           = 2,
    parameter int OV_STICKY_EN = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dsp_i_valid,
    output logic                        dsp_i_ready,
    input  logic [E203_XLEN-1:0]        dsp_i_wdat,
    input  logic                        dsp_i_ov,
    input  logic                        dsp_i_err,
    input  logic [E203_RFIDX_WIDTH-1:0] dsp_i_rdidx,
    output logic                        dsp_o_wbck_valid,
    input  logic                        dsp_o_wbck_ready,
    output logic [E203_XLEN-1:0]        dsp_o_wbck_wdat,
    output logic [E203_RFIDX_WIDTH-1:0] dsp_o_wbck_rdidx,
    output logic                        dsp_o_wbck_err,
    input  logic                        flush_i,
    input  logic                        ov_clr_i,
    output logic                        ov_sticky_o
);

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    dsp_wbck_ent_t w_in_ent;
    dsp_wbck_ent_t w_head;

    // Ready depends only on registered occupancy, never on the downstream ready.
    assign dsp_i_ready      = ~w_full;
    assign dsp_o_wbck_valid = ~w_empty;
    assign w_push           = dsp_i_valid & ~w_full & ~flush_i;
    assign w_pop            = ~w_empty & dsp_o_wbck_ready & ~flush_i;

    assign w_in_ent.ov    = dsp_i_ov;
    assign w_in_ent.err   = dsp_i_err;
    assign w_in_ent.rdidx = dsp_i_rdidx;
    assign w_in_ent.wdat  = dsp_i_wdat;

    e203_exu_dsp_wbck_buf #(
        .DP (DP),
        .DW (DSP_WBCK_DW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush_i),
        .i_wdat  (w_in_ent),
        .o_rdat  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign dsp_o_wbck_wdat  = w_head.wdat;
    assign dsp_o_wbck_rdidx = w_head.rdidx;
    assign dsp_o_wbck_err   = w_head.err;

    generate
        if (OV_STICKY_EN != 0) begin : g_ov
            logic r_ov_sticky;
            logic w_ov_set;

            // Only results actually retired without error count as saturation events.
            assign w_ov_set = w_pop & w_head.ov & ~w_head.err;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)           r_ov_sticky <= 1'b0;
                else if (w_ov_set) r_ov_sticky <= 1'b1;
                else if (ov_clr_i) r_ov_sticky <= 1'b0;
            end

            assign ov_sticky_o = r_ov_sticky;
        end else begin : g_no_ov
            assign ov_sticky_o = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_e203_exu_dsp_wbck.sv
// Randomized + directed bench; a queue-based model predicts every output cycle.
module tb_e203_exu_dsp_wbck;
    import e203_exu_dsp_wbck_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        dsp_i_valid;
    logic                        dsp_i_ready;
    logic [E203_XLEN-1:0]        dsp_i_wdat;
    logic                        dsp_i_ov;
    logic                        dsp_i_err;
    logic [E203_RFIDX_WIDTH-1:0] dsp_i_rdidx;
    logic                        dsp_o_wbck_valid;
    logic                        dsp_o_wbck_ready;
    logic [E203_XLEN-1:0]        dsp_o_wbck_wdat;
    logic [E203_RFIDX_WIDTH-1:0] dsp_o_wbck_rdidx;
    logic                        dsp_o_wbck_err;
    logic                        flush_i;
    logic                        ov_clr_i;
    logic                        ov_sticky_o;

    int checks = 0;
    int errors = 0;

    e203_exu_dsp_wbck #(.DP(2), .OV_STICKY_EN(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .dsp_i_valid      (dsp_i_valid),
        .dsp_i_ready      (dsp_i_ready),
        .dsp_i_wdat       (dsp_i_wdat),
        .dsp_i_ov         (dsp_i_ov),
        .dsp_i_err        (dsp_i_err),
        .dsp_i_rdidx      (dsp_i_rdidx),
        .dsp_o_wbck_valid (dsp_o_wbck_valid),
        .dsp_o_wbck_ready (dsp_o_wbck_ready),
        .dsp_o_wbck_wdat  (dsp_o_wbck_wdat),
        .dsp_o_wbck_rdidx (dsp_o_wbck_rdidx),
        .dsp_o_wbck_err   (dsp_o_wbck_err),
        .flush_i          (flush_i),
        .ov_clr_i         (ov_clr_i),
        .ov_sticky_o      (ov_sticky_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of accepted results plus a sticky bit.
    typedef struct {
        logic [E203_XLEN-1:0]        wdat;
        logic [E203_RFIDX_WIDTH-1:0] rdidx;
        logic                        err;
        logic                        ov;
    } ent_t;

    ent_t q[$];
    logic m_sticky;
    logic m_push, m_pop, m_set;
    ent_t m_new;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_sticky = 1'b0;
        end else begin
            m_push = dsp_i_valid && (q.size() < 2) && !flush_i;
            m_pop  = (q.size() > 0) && dsp_o_wbck_ready && !flush_i;
            m_set  = m_pop && q[0].ov && !q[0].err;
            m_new.wdat  = dsp_i_wdat;
            m_new.rdidx = dsp_i_rdidx;
            m_new.err   = dsp_i_err;
            m_new.ov    = dsp_i_ov;
            if (flush_i) q.delete();
            else begin
                if (m_pop)  void'(q.pop_front());
                if (m_push) q.push_back(m_new);
            end
            if (m_set)         m_sticky = 1'b1;
            else if (ov_clr_i) m_sticky = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", {63'd0, dsp_o_wbck_valid}, {63'd0, q.size() != 0});
            chk("ready", {63'd0, dsp_i_ready}, {63'd0, q.size() < 2});
            chk("sticky", {63'd0, ov_sticky_o}, {63'd0, m_sticky});
            if (q.size() != 0) begin
                chk("wdat", {32'd0, dsp_o_wbck_wdat}, {32'd0, q[0].wdat});
                chk("rdidx", {59'd0, dsp_o_wbck_rdidx}, {59'd0, q[0].rdidx});
                chk("err", {63'd0, dsp_o_wbck_err}, {63'd0, q[0].err});
            end
        end
    end

    task automatic drv(input logic v, input logic [31:0] d, input logic ov, input logic er,
                       input logic [4:0] rd, input logic rdy, input logic fl, input logic clr);
        dsp_i_valid      = v;
        dsp_i_wdat       = d;
        dsp_i_ov         = ov;
        dsp_i_err        = er;
        dsp_i_rdidx      = rd;
        dsp_o_wbck_ready = rdy;
        flush_i          = fl;
        ov_clr_i         = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        dsp_i_valid = 0; dsp_i_wdat = 0; dsp_i_ov = 0; dsp_i_err = 0; dsp_i_rdidx = 0;
        dsp_o_wbck_ready = 0; flush_i = 0; ov_clr_i = 0;
        #3;
        chk("rst_valid", {63'd0, dsp_o_wbck_valid}, 64'd0);
        chk("rst_ready", {63'd0, dsp_i_ready}, 64'd1);
        chk("rst_sticky", {63'd0, ov_sticky_o}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Single saturated result, downstream always ready.
        drv(1, 32'h7fffffff, 1, 0, 5'd5, 1, 0, 0);
        chk("t1_valid", {63'd0, dsp_o_wbck_valid}, 64'd1);
        chk("t1_wdat", {32'd0, dsp_o_wbck_wdat}, 64'h7fffffff);
        chk("t1_rdidx", {59'd0, dsp_o_wbck_rdidx}, 64'd5);
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t1_sticky", {63'd0, ov_sticky_o}, 64'd1);
        chk("t1_empty", {63'd0, dsp_o_wbck_valid}, 64'd0);

        // Clear colliding with a setting pop: set wins, then clear alone works.
        drv(1, 32'h1234, 1, 0, 5'd3, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 1);
        chk("clr_set_wins", {63'd0, ov_sticky_o}, 64'd1);
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        chk("clr_alone", {63'd0, ov_sticky_o}, 64'd0);

        // Three back-to-back with downstream stalled.
        drv(1, 32'h11, 0, 0, 5'd1, 0, 0, 0);
        drv(1, 32'h22, 0, 0, 5'd2, 0, 0, 0);
        chk("full_ready", {63'd0, dsp_i_ready}, 64'd0);
        drv(1, 32'h33, 0, 0, 5'd3, 0, 0, 0);
        chk("held_head_A", {32'd0, dsp_o_wbck_wdat}, 64'h11);
        drv(1, 32'h33, 0, 0, 5'd3, 1, 0, 0);
        chk("head_B", {32'd0, dsp_o_wbck_wdat}, 64'h22);
        chk("ready_after_pop", {63'd0, dsp_i_ready}, 64'd1);
        drv(1, 32'h33, 0, 0, 5'd3, 1, 0, 0);
        chk("head_C", {32'd0, dsp_o_wbck_wdat}, 64'h33);
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        chk("drained", {63'd0, dsp_o_wbck_valid}, 64'd0);

        // Continuous stream with both sides active.
        for (int i = 0; i < 10; i++)
            drv(1, $urandom, 1'($urandom), 0, 5'($urandom), 1, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 1);
        drv(0, 0, 0, 0, 0, 1, 0, 1);

        // Flush with two entries held, second saturated.
        drv(1, 32'hd0, 0, 0, 5'd7, 0, 0, 1);
        drv(1, 32'he0, 1, 0, 5'd8, 0, 0, 0);
        drv(1, 32'hf0, 0, 0, 5'd9, 1, 1, 0);
        chk("flush_valid", {63'd0, dsp_o_wbck_valid}, 64'd0);
        chk("flush_sticky", {63'd0, ov_sticky_o}, 64'd0);
        chk("flush_ready", {63'd0, dsp_i_ready}, 64'd1);

        // Async reset mid-transfer with one entry held and sticky set.
        drv(1, 32'haa, 1, 0, 5'd1, 1, 0, 0);
        drv(1, 32'hbb, 0, 0, 5'd2, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_sticky", {63'd0, ov_sticky_o}, 64'd1);
        chk("pre_rst_valid", {63'd0, dsp_o_wbck_valid}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, dsp_o_wbck_valid}, 64'd0);
        chk("arst_ready", {63'd0, dsp_i_ready}, 64'd1);
        chk("arst_sticky", {63'd0, ov_sticky_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            drv($urandom_range(0, 9) < 7, $urandom, 1'($urandom), $urandom_range(0, 9) < 2,
                5'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 5);

        drv(0, 0, 0, 0, 0, 1, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
